// File: rtl/multdiv_ctrl.sv
// Multicycle sequencer for the shared combinational multiplier / array divider:
// latches operands, waits a fixed settle time, captures the result and pulses ready.
module multdiv_ctrl #(
  parameter int unsigned MULT_CYCLES = 32'd4,
  parameter int unsigned DIV_CYCLES  = 32'd8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] dp_operandA,
  output logic [31:0] dp_operandB,
  output logic        dp_isDiv,
  input  logic [31:0] mult_result,
  input  logic        mult_exception,
  input  logic [31:0] div_result,
  input  logic        div_exception,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_inputRDY,
  output logic        data_resultRDY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] MULT_LOAD = 8'(MULT_CYCLES - 32'd1);
  localparam logic [7:0] DIV_LOAD  = 8'(DIV_CYCLES - 32'd1);

  state_t      state_r;
  logic [7:0]  cnt_r;
  logic [31:0] dp_a_r;
  logic [31:0] dp_b_r;
  logic        dp_div_r;
  logic [31:0] result_r;
  logic        exception_r;
  logic        result_rdy_r;

  logic        accept_s;
  logic [31:0] cap_result_s;
  logic        cap_exception_s;

  // The divider only sees B[15:0]; anything not representable in 16 signed bits is rejected.
  function automatic logic b_out_of_range(input logic [31:0] b);
    return (b[31:15] != {17{b[15]}});
  endfunction

  // Request acceptance and selection of the value to capture at the end of RUN.
  always_comb begin
    accept_s        = 1'b0;
    cap_result_s    = 32'd0;
    cap_exception_s = 1'b0;
    if (state_r != RUN) begin
      accept_s = ctrl_MULT | ctrl_DIV;
    end else begin
      accept_s = 1'b0;
    end
    if (!dp_div_r) begin
      cap_result_s    = mult_result;
      cap_exception_s = mult_exception;
    end else if (b_out_of_range(dp_b_r)) begin
      cap_result_s    = 32'd0;
      cap_exception_s = 1'b1;
    end else if (div_exception) begin
      cap_result_s    = 32'd0;
      cap_exception_s = 1'b1;
    end else begin
      cap_result_s    = div_result;
      cap_exception_s = 1'b0;
    end
  end

  // Controller state, operand latches, settle counter and result capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      cnt_r        <= 8'd0;
      dp_a_r       <= 32'd0;
      dp_b_r       <= 32'd0;
      dp_div_r     <= 1'b0;
      result_r     <= 32'd0;
      exception_r  <= 1'b0;
      result_rdy_r <= 1'b0;
    end else begin
      result_rdy_r <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          // DONE accepts exactly like IDLE so operations can run back to back.
          if (accept_s) begin
            dp_a_r   <= data_operandA;
            dp_b_r   <= data_operandB;
            dp_div_r <= ctrl_DIV;
            cnt_r    <= ctrl_DIV ? DIV_LOAD : MULT_LOAD;
            state_r  <= RUN;
          end else begin
            state_r  <= IDLE;
          end
        end
        RUN: begin
          if (cnt_r == 8'd0) begin
            result_r     <= cap_result_s;
            exception_r  <= cap_exception_s;
            result_rdy_r <= 1'b1;
            state_r      <= DONE;
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign dp_operandA    = dp_a_r;
  assign dp_operandB    = dp_b_r;
  assign dp_isDiv       = dp_div_r;
  assign data_result    = result_r;
  assign data_exception = exception_r;
  assign data_resultRDY = result_rdy_r;
  assign data_inputRDY  = (state_r != RUN);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl: directed scenarios plus random traffic, with a
// behavioural datapath model and an arithmetic reference for every accepted request.
module tb_multdiv_ctrl;

  localparam int MC = 4;
  localparam int DC = 8;

  logic        clock;
  logic        reset_n;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB;
  logic [31:0] dp_operandA, dp_operandB;
  logic        dp_isDiv;
  logic [31:0] mult_result, div_result;
  logic        mult_exception, div_exception;
  logic [31:0] data_result;
  logic        data_exception, data_inputRDY, data_resultRDY;

  multdiv_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clock(clock), .reset_n(reset_n),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .dp_operandA(dp_operandA), .dp_operandB(dp_operandB), .dp_isDiv(dp_isDiv),
    .mult_result(mult_result), .mult_exception(mult_exception),
    .div_result(div_result), .div_exception(div_exception),
    .data_result(data_result), .data_exception(data_exception),
    .data_inputRDY(data_inputRDY), .data_resultRDY(data_resultRDY)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Combinational datapath: multiplier and a 16-bit-divisor divider (garbage on /0).
  logic signed [63:0] prod;
  logic signed [31:0] bdiv;
  always_comb begin
    prod = $signed({{32{dp_operandA[31]}}, dp_operandA}) * $signed({{32{dp_operandB[31]}}, dp_operandB});
    mult_result    = prod[31:0];
    mult_exception = (prod[63:31] != {33{prod[31]}});
    bdiv = $signed({{16{dp_operandB[15]}}, dp_operandB[15:0]});
    div_exception = (dp_operandB[15:0] == 16'd0);
    if (div_exception) div_result = 32'hBAD0_BAD0;
    else               div_result = $signed(dp_operandA) / bdiv;
  end

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          busy_lo = -1;
  int          busy_hi = -2;
  logic [31:0] m_a = 32'd0, m_b = 32'd0;
  logic        m_div = 1'b0;
  logic [31:0] last_res = 32'd0;
  logic        last_exc = 1'b0;
  bit          started = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference: {exception, result} from the operation's arithmetic definition.
  function automatic logic [32:0] ref_op(input logic d, input logic signed [31:0] a,
                                         input logic signed [31:0] b);
    longint p;
    logic signed [31:0] quo;
    if (d) begin
      if (b < -32'sd32768 || b > 32'sd32767 || b == 32'sd0) return {1'b1, 32'd0};
      quo = a / b;
      return {1'b0, quo};
    end
    p = longint'(a) * longint'(b);
    return {(p > 64'sd2147483647 || p < -64'sd2147483648), p[31:0]};
  endfunction

  function automatic bit model_busy(input int c);
    return (c >= busy_lo && c <= busy_hi);
  endfunction

  // Drive one cycle of inputs; the model decides acceptance from its own timeline.
  task automatic step(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] r;
    int n;
    exp_t e;
    @(negedge clock); #1;
    ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
    if ((m || d) && !model_busy(cyc)) begin
      n = d ? DC : MC;
      r = ref_op(d, a, b);
      e.res = r[31:0]; e.exc = r[32]; e.due = cyc + n + 1;
      q.push_back(e);
      busy_lo = cyc + 1; busy_hi = cyc + n;
      m_a = a; m_b = b; m_div = d;
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, $urandom, $urandom);
  endtask

  // Monitor: compares handshake, held datapath operands and held result every cycle.
  always @(negedge clock) begin
    exp_t e;
    bit   exp_pulse;
    if (started && reset_n) begin
      check("inputRDY", {31'd0, data_inputRDY}, {31'd0, !model_busy(cyc)});
      exp_pulse = (q.size() > 0) && (q[0].due == cyc);
      check("resultRDY", {31'd0, data_resultRDY}, {31'd0, exp_pulse});
      if (exp_pulse) begin
        e = q.pop_front();
        last_res = e.res;
        last_exc = e.exc;
      end
      check("result", data_result, last_res);
      check("exception", {31'd0, data_exception}, {31'd0, last_exc});
      if (model_busy(cyc)) begin
        check("dp_isDiv", {31'd0, dp_isDiv}, {31'd0, m_div});
        check("dp_operandA", dp_operandA, m_a);
        check("dp_operandB", dp_operandB, m_b);
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst dp_operandA", dp_operandA, 32'd0);
    check("rst dp_operandB", dp_operandB, 32'd0);
    check("rst dp_isDiv", {31'd0, dp_isDiv}, 32'd0);
    check("rst data_result", data_result, 32'd0);
    check("rst data_exception", {31'd0, data_exception}, 32'd0);
    check("rst resultRDY", {31'd0, data_resultRDY}, 32'd0);
    check("rst inputRDY", {31'd0, data_inputRDY}, 32'd1);
  endtask

  function automatic logic [31:0] rand_b();
    case ($urandom_range(0, 6))
      0: return $urandom;
      1: return 32'($urandom_range(0, 65535)) - 32'd32768;
      2: return 32'd0;
      3: return 32'd32767;
      4: return 32'h0000_8000;
      5: return 32'hFFFF_7FFF;
      default: return 32'hFFFF_8000;
    endcase
  endfunction

  initial begin
    reset_n = 1'b0;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = 32'd0; data_operandB = 32'd0;
    #1;
    check_reset_outputs();
    @(negedge clock); #2;
    reset_n = 1'b1;
    started = 1'b1;
    idle(2);

    step(1'b0, 1'b1, 32'd100, 32'd7);              // 100/7 = 14
    idle(10);
    step(1'b0, 1'b1, -32'sd100, 32'd7);            // 0xFFFFFFF2
    idle(DC);
    step(1'b1, 1'b0, 32'd3, -32'sd5);              // back-to-back from DONE
    idle(MC + 2);
    step(1'b0, 1'b1, 32'd77, 32'd0);               // divide by zero
    idle(DC + 1);
    step(1'b0, 1'b1, 32'd77, 32'd40000);           // divisor out of range
    idle(DC + 1);
    step(1'b1, 1'b1, 32'd45, 32'd9);               // collision: DIV wins
    idle(2);
    step(1'b1, 1'b0, 32'd6, 32'd6);                // RUN cycle 3: ignored
    idle(DC + 2);

    // Reset in RUN cycle 4 abandons the operation
    step(1'b0, 1'b1, 32'd1000, 32'd3);
    idle(3);
    @(negedge clock); #1;
    q.delete();
    busy_lo = -1; busy_hi = -2;
    last_res = 32'd0; last_exc = 1'b0;
    reset_n = 1'b0;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clock); #2;
    reset_n = 1'b1;
    idle(DC + 3);
    step(1'b0, 1'b1, 32'd50, 32'd5);               // 50/5 = 10
    idle(DC + 2);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 2000)) - 32'd1000;
      if ($urandom_range(0, 2) == 0) step($urandom_range(0, 1), $urandom_range(0, 1), a, rand_b());
      else idle(1);
    end

    for (int i = 0; i < 40 && q.size() > 0; i++) idle(1);
    check("drain", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
